// File: rtl/slave_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : slave_receiver
//  Brief    : Serial frame receiver with START/STOP detection, LSB-first data.
//             Optional input synchronizer enabled by SLAVE_RECEIVER_SYNC_EN.
//  Revision : 1.0
// ============================================================================
module slave_receiver #(
  parameter int MESSAGE_LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sda,
  input  logic                      scl,
  output logic [MESSAGE_LENGTH-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      error
);

  localparam int c_CNT_W = $clog2(MESSAGE_LENGTH + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  logic w_sda_s;
  logic w_scl_s;

`ifdef SLAVE_RECEIVER_SYNC_EN
  logic [1:0] r_sda_sync;
  logic [1:0] r_scl_sync;

  // Synchronizers preset high so the idle bus never looks like a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sda_sync <= 2'b11;
      r_scl_sync <= 2'b11;
    end else begin
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_sync <= {r_scl_sync[0], scl};
    end
  end

  assign w_sda_s = r_sda_sync[1];
  assign w_scl_s = r_scl_sync[1];
`else
  assign w_sda_s = sda;
  assign w_scl_s = scl;
`endif

  state_t                    r_state;
  state_t                    w_state_next;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [c_CNT_W-1:0]        w_cnt_next;
  logic [MESSAGE_LENGTH-1:0] r_shift;
  logic [MESSAGE_LENGTH-1:0] w_shift_next;
  logic [MESSAGE_LENGTH-1:0] r_data;
  logic                      r_valid;
  logic                      r_error;
  logic                      r_sda_p;
  logic                      r_scl_p;
  logic                      w_load;
  logic                      w_abort;
  logic                      w_start;
  logic                      w_stop;
  logic                      w_rise;

  assign w_start = r_scl_p & w_scl_s & r_sda_p & ~w_sda_s;
  assign w_stop  = r_scl_p & w_scl_s & ~r_sda_p & w_sda_s;
  assign w_rise  = ~r_scl_p & w_scl_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_sda_p <= 1'b1;
      r_scl_p <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
      r_valid <= w_load;
      r_error <= w_abort;
      r_sda_p <= w_sda_s;
      r_scl_p <= w_scl_s;
      if (w_load) begin
        r_data <= w_shift_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_load       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_RECV;
          w_cnt_next   = '0;
        end
      end
      S_RECV: begin
        if (w_start) begin
          // Repeated start only counts as an abort once bits have arrived.
          w_abort    = (r_cnt != '0);
          w_cnt_next = '0;
        end else if (w_stop) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_rise) begin
          for (int i = 0; i < MESSAGE_LENGTH; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
              w_shift_next[i] = w_sda_s;
            end
          end
          w_cnt_next = r_cnt + c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(MESSAGE_LENGTH - 1)) begin
            w_load       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign error = r_error;
  assign busy  = (r_state == S_RECV);

endmodule
`default_nettype wire

// File: tb/tb_slave_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slave_receiver
//  Brief    : Table-driven self-checking bench with a frame scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_slave_receiver;

  localparam int c_ML = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            sda;
  logic            scl;
  logic [c_ML-1:0] data;
  logic            valid;
  logic            busy;
  logic            error;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;
  logic [c_ML-1:0] q_exp[$];
  logic [c_ML-1:0] model_data;

  always #5 clk = ~clk;

  slave_receiver #(.MESSAGE_LENGTH(c_ML)) dut (
    .clk   (clk),
    .rst   (rst),
    .sda   (sda),
    .scl   (scl),
    .data  (data),
    .valid (valid),
    .busy  (busy),
    .error (error)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (valid || error) chk("valid_error_exclusive", {31'd0, valid & error}, 32'd0);
    if (valid) begin
      n_valid++;
      if (q_exp.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("frame_data", {24'd0, data}, {24'd0, q_exp.pop_front()});
      end
    end
    if (error) n_err++;
  end

  task automatic step(input logic s_sda, input logic s_scl);
    @(negedge clk);
    sda = s_sda;
    scl = s_scl;
  endtask

  // Master style: sda changes together with the rising scl edge.
  task automatic bit_tx(input logic b);
    step(sda, 1'b0);
    step(b, 1'b1);
    step(b, 1'b1);
  endtask

  task automatic send_bits(input logic [c_ML-1:0] val, input int n);
    for (int i = 0; i < n; i++) bit_tx(val[i]);
  endtask

  task automatic start_cond();
    if (scl && !sda) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
    end else if (!scl) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic stop_cond();
    if (scl && sda) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end else if (!scl) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 16 && q_exp.size() != 0; i++) @(negedge clk);
    chk(name, q_exp.size(), 32'd0);
    q_exp.delete();
  endtask

  // kind 0: START + frame; 1: START + pre bits + STOP; 2: START + pre bits + START + frame
  typedef struct {
    int              kind;
    int              pre_n;
    logic [c_ML-1:0] pre_val;
    logic [c_ML-1:0] frame;
    int              exp_valid;
    int              exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    start_cond();
    repeat (2) @(negedge clk);
    chk({name, "_busy_in_frame"}, {31'd0, busy}, 32'd1);
    if (v.kind != 0) begin
      send_bits(v.pre_val, v.pre_n);
      if (v.kind == 1) stop_cond();
      else start_cond();
    end
    if (v.kind != 1) begin
      q_exp.push_back(v.frame);
      model_data = v.frame;
      send_bits(v.frame, c_ML);
    end
    if (scl && !sda) step(1'b1, 1'b1);
    repeat (8) @(negedge clk);
    drain({name, "_drain"});
    chk({name, "_valid_cnt"}, n_valid - v0, v.exp_valid);
    chk({name, "_error_cnt"}, n_err - e0, v.exp_err);
    chk({name, "_data"}, {24'd0, data}, {24'd0, model_data});
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    int e0;
    vecs[0] = '{0, 0, 8'h00, 8'hA5, 1, 0};
    vecs[1] = '{0, 0, 8'h00, 8'h3C, 1, 0};
    vecs[2] = '{1, 3, 8'h03, 8'h00, 0, 1};
    vecs[3] = '{2, 5, 8'h1D, 8'h81, 1, 1};
    vecs[4] = '{0, 0, 8'h00, 8'h00, 1, 0};
    vecs[5] = '{0, 0, 8'h00, 8'hFF, 1, 0};
    vecs[6] = '{1, 7, 8'h15, 8'h00, 0, 1};
    vecs[7] = '{1, 0, 8'h00, 8'h00, 0, 1};

    rst = 1'b1;
    sda = 1'b1;
    scl = 1'b1;
    model_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_false_start", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a frame discards it silently.
    v0 = n_valid;
    e0 = n_err;
    start_cond();
    send_bits(8'h0A, 4);
    @(negedge clk);
    rst = 1'b1;
    step(sda, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    model_data = '0;
    repeat (4) @(negedge clk);
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid_cnt", n_valid - v0, 32'd0);
    chk("midrst_error_cnt", n_err - e0, 32'd0);
    run_vec('{0, 0, 8'h00, 8'hFF, 1, 0}, "after_rst");

    // sda activity while scl is low must never start a frame.
    v0 = n_valid;
    e0 = n_err;
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(~sda, 1'b0);
      step(sda, 1'b0);
      chk("toggle_busy", {31'd0, busy}, 32'd0);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (6) @(negedge clk);
    chk("toggle_busy_end", {31'd0, busy}, 32'd0);
    chk("toggle_valid_cnt", n_valid - v0, 32'd0);
    chk("toggle_error_cnt", n_err - e0, 32'd0);
    run_vec(vecs[0], "final_a5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slave_receiver.md
SLAVE_RECEIVER -- requirements
Module: slave_receiver

Interface
REQ-001 SHALL have parameter MESSAGE_LENGTH, default 8, number of data bits per frame (must be 2 or more).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port sda  input  1  serial data line, driven by the master stage.
REQ-005 SHALL have port scl  input  1  serial clock line, driven by the master stage.
REQ-006 SHALL have port data  output  MESSAGE_LENGTH  last complete received frame.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when data is updated.
REQ-008 SHALL have port busy  output  1  high while a frame is being received.
REQ-009 SHALL have port error  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-010 SHALL form sampled lines sda_s/scl_s (REQ-030/031) and registered copies sda_p/scl_p from the previous cycle.
REQ-011 SHALL define START as scl_p=1, scl_s=1, sda_p=1, sda_s=0.
REQ-012 SHALL define STOP as scl_p=1, scl_s=1, sda_p=0, sda_s=1.
REQ-013 SHALL define RISE as scl_p=0, scl_s=1; sda_s in that same cycle is the bit value, since the master changes sda and raises scl on the same edge.
REQ-014 SHALL ignore any sda change while scl_p=0 or scl_s=0 for START/STOP purposes.
REQ-015 SHALL implement states IDLE and RECV; busy=1 exactly in RECV.
REQ-016 IDLE: on START, go to RECV, clear bit counter; all other events ignored.
REQ-017 RECV: on RISE, store sda_s into shift register at index = bit counter (LSB first, bit 0 first), increment counter.
REQ-018 RECV: on the RISE that stores bit MESSAGE_LENGTH-1, load data with the full frame, assert valid next cycle for one cycle, return to IDLE.
REQ-019 RECV: STOP with fewer than MESSAGE_LENGTH bits: pulse error for one cycle, return to IDLE, data unchanged.
REQ-020 RECV: START (repeated start): pulse error only if counter is non-zero, clear counter, remain in RECV.
REQ-021 START/STOP and RISE are mutually exclusive by definition; no priority rule needed.
REQ-022 valid and error SHALL never be high in the same cycle.
REQ-023 data SHALL hold its value between frames; only REQ-018 changes it.
REQ-024 Bit counter width SHALL be ceil(log2(MESSAGE_LENGTH+1)) bits; it never exceeds MESSAGE_LENGTH.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, counter=0, shift register=0, data=0, valid=0, busy=0, error=0.
REQ-026 sda_p/scl_p (and synchronizer flops) SHALL reset to 1 (idle-high bus), so no false START after reset.
REQ-027 Reset mid-frame SHALL discard the partial frame with no valid or error pulse.

Configuration
REQ-030 With SLAVE_RECEIVER_SYNC_EN defined: sda_s/scl_s SHALL come from a two-flop synchronizer per line, adding 2 cycles latency to all events.
REQ-031 Without SLAVE_RECEIVER_SYNC_EN: sda_s/scl_s SHALL be the raw inputs sda/scl (same-clock master only).

Verification
REQ-040 Idle-high lines, START, 8 bits of 0xA5 LSB first (each scl low then high) -> data=0xA5, valid high exactly 1 cycle, busy low after.
REQ-041 Direct connection to the master stage with data input 0x3C, no sync macro -> data=0x3C, valid pulses once per master frame.
REQ-042 START, 3 bits, then STOP -> error pulses 1 cycle, valid stays 0, data keeps previous value.
REQ-043 START, 5 bits, repeated START, 8 bits of 0x81 -> one error pulse, then data=0x81 with one valid pulse.
REQ-044 rst asserted after 4 bits, then released -> all outputs 0, no valid/error; next full frame 0xFF received correctly.
REQ-045 sda toggled repeatedly while scl=0 in IDLE -> busy, valid and error stay 0; repeat REQ-040 with SLAVE_RECEIVER_SYNC_EN -> same result, valid 2 cycles later.
